// File: rtl/bram_rf_pkg.sv
// Shared constants and types for the BRAM_RF port arbiter.
// The read-return tag records which requester owns each in-flight read beat.
package bram_rf_pkg;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int RD_LAT  = 2;
  localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [3:0] WE_FULL = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
  } rd_tag_t;

endpackage

// File: rtl/bram_rf_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, circularly.
// Returns both a one-hot grant and the winning index.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((32'(ptr) + 32'(i)) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/bram_rf_arbiter.sv
// Shares the single BRAM_RF port among requesters as whole round-robin bursts
// and steers returned read data back to the owner after the fixed read latency.
module bram_rf_arbiter
  import bram_rf_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          req_we_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*LEN_W-1:0]    req_len_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         addrb,
  output logic [DATA_W-1:0]         dinb,
  input  logic [DATA_W-1:0]         doutb,
  output logic                      enb,
  output logic [3:0]                web,
  output state_t                    state_dbg
);

  state_t             state, state_next;
  logic [OWNER_W-1:0] owner;
  logic               we_r;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   cnt;
  logic [OWNER_W-1:0] rr_ptr;
  rd_tag_t            pipe [RD_LAT];
  logic               pipe_any;

  logic [N_REQ-1:0]   arb_gnt;
  logic [OWNER_W-1:0] arb_idx;
  logic               arb_any;

  rr_arbiter #(.N(N_REQ), .W(OWNER_W)) u_rr (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt_o      = '0;
    addrb      = '0;
    dinb       = '0;
    web        = '0;
    case (state)
      IDLE: if (arb_any) state_next = BURST;
      BURST: begin
        gnt_o[owner] = 1'b1;
        addrb        = cur_addr;
        if (we_r) begin
          web  = WE_FULL;
          dinb = req_wdata_i[int'(owner)*DATA_W +: DATA_W];
        end
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_any = pipe_any | pipe[i].valid;
  end

  // Enable must stay up while reads drain, otherwise the BRAM output stage stalls.
  assign enb       = (state == BURST) | pipe_any;
  assign busy_o    = enb;
  assign state_dbg = state;

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (pipe[RD_LAT-1].valid) begin
      rvalid_o[pipe[RD_LAT-1].owner] = 1'b1;
      rdata_o                        = doutb;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner    <= '0;
      we_r     <= 1'b0;
      cur_addr <= '0;
      cnt      <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].valid <= (state == BURST) && !we_r;
      pipe[0].owner <= owner;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (state == IDLE && arb_any) begin
        owner    <= arb_idx;
        we_r     <= |(req_we_i & arb_gnt);
        cur_addr <= req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
        cnt      <= req_len_i[int'(arb_idx)*LEN_W +: LEN_W];
        if (int'(arb_idx) == N_REQ - 1) rr_ptr <= '0;
        else                            rr_ptr <= arb_idx + 1'b1;
      end else if (state == BURST) begin
        cur_addr <= cur_addr + 1'b1;
        cnt      <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_rf_arbiter.sv
// Bench for bram_rf_arbiter: a BRAM model with a 2-stage read path, requester
// drivers, and a scoreboard fed by a burst-level reference model.
module tb_bram_rf_arbiter;
  import bram_rf_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic [N_REQ-1:0]        req_i = '0;
  logic [N_REQ-1:0]        req_we_i = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr_i = '0;
  logic [N_REQ*LEN_W-1:0]  req_len_i = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata_i = '0;
  logic [N_REQ-1:0]        gnt_o, rvalid_o;
  logic [DATA_W-1:0]       rdata_o, dinb, doutb;
  logic                    busy_o, enb;
  logic [ADDR_W-1:0]       addrb;
  logic [3:0]              web;
  state_t                  state_dbg;

  always #5 CLK = ~CLK;

  bram_rf_arbiter dut (
    .CLK(CLK), .RST(RST), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web),
    .state_dbg(state_dbg)
  );

  // BRAM model: address cycle c -> data on doutb in cycle c+2, write commits at the edge.
  logic [DATA_W-1:0] bram [DEPTH];
  logic [DATA_W-1:0] rd1;
  logic              load_en = 1'b1;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;

  always @(posedge CLK) begin
    if (load_en) bram[load_addr] <= load_data;
    else if (enb) begin
      if (web == WE_FULL) bram[addrb] <= dinb;
      rd1   <= bram[addrb];
      doutb <= rd1;
    end
  end

  // Reference model and scoreboard state
  typedef struct {
    int                owner;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    bit                first;
  } beat_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  beat_t             beat_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_owner_q[$];
  int                model_ptr = 0;

  logic              r_we   [N_REQ];
  logic [ADDR_W-1:0] r_addr [N_REQ];
  logic [LEN_W-1:0]  r_len  [N_REQ];
  logic [DATA_W-1:0] wq     [N_REQ][16];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit overlap_seen = 1'b0;
  logic [N_REQ-1:0] prev_gnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plans a set of simultaneous requests: serves them in round-robin order,
  // one whole burst at a time, updating the reference memory as it goes.
  task automatic plan(input logic [N_REQ-1:0] pend_in);
    logic [N_REQ-1:0] pend = pend_in;
    while (pend != '0) begin
      int r = -1;
      for (int i = 0; i < N_REQ; i++) begin
        int c = (model_ptr + i) % N_REQ;
        if (r < 0 && pend[c]) r = c;
      end
      for (int k = 0; k <= int'(r_len[r]); k++) begin
        beat_t b;
        b.owner = r;
        b.addr  = ADDR_W'((int'(r_addr[r]) + k) % DEPTH);
        b.we    = r_we[r];
        b.wdata = wq[r][k];
        b.first = (k == 0);
        beat_q.push_back(b);
        if (r_we[r]) ref_mem[b.addr] = wq[r][k];
        else begin
          exp_q.push_back(ref_mem[b.addr]);
          exp_owner_q.push_back(r);
        end
      end
      pend[r]   = 1'b0;
      model_ptr = (r + 1) % N_REQ;
    end
  endtask

  task automatic drive_req(input int r, input bit chk_lat);
    int k = 0;
    int waited = 0;
    req_we_i[r] = r_we[r];
    req_addr_i[r*ADDR_W +: ADDR_W] = r_addr[r];
    req_len_i[r*LEN_W +: LEN_W]    = r_len[r];
    req_wdata_i[r*DATA_W +: DATA_W] = wq[r][0];
    req_i[r] = 1'b1;
    while (k <= int'(r_len[r]) && waited < 400) begin
      @(negedge CLK);
      waited++;
      if (gnt_o[r]) begin
        if (k == 0 && chk_lat) check("grant_latency", 64'(waited), 64'd2);
        req_i[r] = 1'b0;
        k++;
        if (k <= int'(r_len[r])) begin
          @(posedge CLK);
          #1 req_wdata_i[r*DATA_W +: DATA_W] = wq[r][k];
        end
      end
    end
    if (k <= int'(r_len[r])) begin
      req_i[r] = 1'b0;
      check("grant_timeout", 64'(k), 64'(int'(r_len[r]) + 1));
    end
  endtask

  task automatic run_phase(input logic [N_REQ-1:0] m, input bit chk_lat);
    int b = 0;
    plan(m);
    @(posedge CLK);
    #1;
    fork
      if (m[0]) drive_req(0, chk_lat);
      if (m[1]) drive_req(1, chk_lat);
      if (m[2]) drive_req(2, chk_lat);
      if (m[3]) drive_req(3, chk_lat);
    join
    while ((beat_q.size() != 0 || exp_q.size() != 0) && b < 50) begin
      @(negedge CLK);
      b++;
    end
    check("drain_pending", 64'(beat_q.size() + exp_q.size()), 64'd0);
    beat_q.delete(); exp_q.delete(); exp_owner_q.delete();
    @(negedge CLK);
    check("idle_busy", 64'(busy_o), 64'd0);
  endtask

  // Monitor: every issued beat and every returned read is checked against the queues.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      if (gnt_o != '0) begin
        if (beat_q.size() == 0) check("unexpected_gnt", 64'(gnt_o), 64'd0);
        else begin
          beat_t b;
          logic [N_REQ-1:0] oh;
          b = beat_q.pop_front();
          oh = '0;
          oh[b.owner] = 1'b1;
          check("gnt_owner", 64'(gnt_o), 64'(oh));
          check("addrb", 64'(addrb), 64'(b.addr));
          check("web", 64'(web), b.we ? 64'(WE_FULL) : 64'd0);
          if (b.we) check("dinb", 64'(dinb), 64'(b.wdata));
          if (b.first) check("bubble", 64'(prev_gnt), 64'd0);
          check("enb_on_gnt", 64'(enb), 64'd1);
        end
      end
      if (rvalid_o != '0) begin
        if (exp_q.size() == 0) check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
        else begin
          logic [DATA_W-1:0] d;
          logic [N_REQ-1:0]  oh;
          int                o;
          d = exp_q.pop_front();
          o = exp_owner_q.pop_front();
          oh = '0;
          oh[o] = 1'b1;
          check("rvalid_owner", 64'(rvalid_o), 64'(oh));
          check("rdata", 64'(rdata_o), 64'(d));
          check("enb_on_rvalid", 64'(enb), 64'd1);
        end
      end
      if (rvalid_o[0] && gnt_o[1] && web == WE_FULL) overlap_seen = 1'b1;
      prev_gnt = gnt_o;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    // Preload every BRAM word with random data while reset is held.
    for (int a = 0; a < DEPTH; a++) begin
      logic [DATA_W-1:0] v;
      v = $urandom;
      if (a == 1) v = 32'd15;
      if (a == 2) v = 32'd20;
      if (a == 3) v = 32'd42;
      if (a == 4) v = 32'd65;
      ref_mem[a] = v;
      load_addr  = ADDR_W'(a);
      load_data  = v;
      @(posedge CLK);
      #1;
    end
    load_en = 1'b0;
    @(negedge CLK);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_addrb", 64'(addrb), 64'd0);
    check("rst_dinb", 64'(dinb), 64'd0);
    check("rst_enb", 64'(enb), 64'd0);
    check("rst_web", 64'(web), 64'd0);
    RST = 1'b0;
    mon_en = 1'b1;

    // Preloaded read burst
    r_we[0] = 1'b0; r_addr[0] = 13'd1; r_len[0] = 4'd3;
    run_phase(4'b0001, 1'b1);

    // Write burst then read it back
    r_we[1] = 1'b1; r_addr[1] = 13'd33; r_len[1] = 4'd1;
    wq[1][0] = 32'd1111; wq[1][1] = 32'd2222;
    run_phase(4'b0010, 1'b1);
    check("ref_wr33", 64'(ref_mem[33]), 64'd1111);
    r_we[1] = 1'b0;
    run_phase(4'b0010, 1'b1);

    // Address wrap at the top of the space
    r_we[2] = 1'b0; r_addr[2] = 13'd8190; r_len[2] = 4'd3;
    run_phase(4'b0100, 1'b1);

    // Reset in the middle of a long read burst
    r_we[3] = 1'b0; r_addr[3] = 13'd300; r_len[3] = 4'd7;
    plan(4'b1000);
    @(posedge CLK);
    #1;
    req_we_i[3] = 1'b0;
    req_addr_i[3*ADDR_W +: ADDR_W] = r_addr[3];
    req_len_i[3*LEN_W +: LEN_W] = r_len[3];
    req_i[3] = 1'b1;
    k = 0;
    for (int w = 0; w < 20 && k < 2; w++) begin
      @(negedge CLK);
      if (gnt_o[3]) begin
        k++;
        req_i[3] = 1'b0;
      end
    end
    check("mid_rst_beats", 64'(k), 64'd2);
    #1;
    RST = 1'b1;
    beat_q.delete(); exp_q.delete(); exp_owner_q.delete();
    model_ptr = 0;
    @(negedge CLK);
    check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    check("mid_rst_gnt", 64'(gnt_o), 64'd0);
    check("mid_rst_enb", 64'(enb), 64'd0);
    check("mid_rst_web", 64'(web), 64'd0);
    #1 RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("post_rst_rvalid", 64'(rvalid_o), 64'd0);
    end

    // All four requesters, single-beat bursts, twice
    for (int rep = 0; rep < 2; rep++) begin
      for (int r = 0; r < N_REQ; r++) begin
        r_we[r] = 1'($urandom_range(0, 1));
        r_addr[r] = ADDR_W'($urandom_range(0, 63));
        r_len[r] = '0;
        wq[r][0] = $urandom;
      end
      run_phase(4'b1111, 1'b0);
    end

    // Read on req0 immediately followed by a write on req1
    overlap_seen = 1'b0;
    r_we[0] = 1'b0; r_addr[0] = 13'd200; r_len[0] = 4'd0;
    r_we[1] = 1'b1; r_addr[1] = 13'd201; r_len[1] = 4'd0; wq[1][0] = $urandom;
    run_phase(4'b0011, 1'b0);
    check("rvalid_gnt_overlap", 64'(overlap_seen), 64'd1);
    r_we[1] = 1'b0;
    run_phase(4'b0010, 1'b1);

    // Randomized mixes of concurrent bursts
    for (int p = 0; p < 40; p++) begin
      logic [N_REQ-1:0] m;
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int r = 0; r < N_REQ; r++) begin
        r_we[r] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) r_addr[r] = ADDR_W'($urandom_range(DEPTH - 20, DEPTH - 1));
        else                           r_addr[r] = ADDR_W'($urandom_range(0, 63));
        r_len[r] = LEN_W'($urandom_range(0, 15));
        for (int j = 0; j < 16; j++) wq[r][j] = $urandom;
      end
      run_phase(m, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_rf_arbiter.md
Name: bram_rf_arbiter

Overview:
- Sequences and shares the single BRAM_RF port (addrb/dinb/doutb/enb/web) among N_REQ requesters, such as SIMD lanes and the load/store unit.
- Grants whole bursts of consecutive addresses with round-robin fairness.
- Drives the BRAM control pins and tracks the fixed 2-cycle read pipeline.
- Routes returned read data to the owning requester with a valid strobe.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 13, BRAM word-address width.
- DATA_W, 32, data word width.
- LEN_W, 4, burst-length field width; burst = len+1 beats (1..16).
- RD_LAT, 2, BRAM read latency in cycles (address cycle to doutb valid).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- req_i  in  N_REQ  per-requester burst request; level, held until first gnt.
- req_we_i  in  N_REQ  1 = write burst, 0 = read burst.
- req_addr_i  in  N_REQ*ADDR_W  burst start address.
- req_len_i  in  N_REQ*LEN_W  beats minus one.
- req_wdata_i  in  N_REQ*DATA_W  current write beat; owner advances on each gnt.
- gnt_o  out  N_REQ  one-hot; high on every cycle a beat of that requester is issued.
- rvalid_o  out  N_REQ  one-hot; read data for that requester is on rdata_o.
- rdata_o  out  DATA_W  read data (doutb pass-through).
- busy_o  out  1  burst active or read in flight.
- addrb  out  ADDR_W  BRAM address.
- dinb  out  DATA_W  BRAM write data.
- doutb  in  DATA_W  BRAM read data.
- enb  out  1  BRAM enable.
- web  out  4  BRAM byte write enables; only 4'b1111 or 4'b0000.

Behaviour:
- Reset values: all outputs 0 (gnt_o, rvalid_o, rdata_o-valid, busy_o, addrb, dinb, enb, web). State=IDLE, rr_ptr=0, read pipeline cleared.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_i is set, pick the first set requester at or after rr_ptr (circular).
  - Register owner, we, addr, len; next state BURST. rr_ptr <= owner+1 mod N_REQ.
  - If no requests, stay IDLE.
- BURST, each cycle:
  - Drive addrb = cur_addr, gnt_o[owner] = 1, enb = 1.
  - If we: web = 4'b1111 and dinb = req_wdata_i[owner]. Otherwise web = 0.
  - Advance cur_addr <= cur_addr+1; it wraps modulo 2^ADDR_W (8191 -> 0).
  - Decrement the beat counter. After the beat issued with count=0, go to IDLE.
- Grant latency: request seen in IDLE cycle t → first beat/gnt at t+1; burst occupies t+1..t+1+len.
- One mandatory IDLE bubble between bursts, even if requests are pending.
- Read return:
  - Beat issued in cycle c → rvalid_o[owner] = 1 and rdata_o = doutb in cycle c+RD_LAT.
  - Implemented as a RD_LAT-deep shift register of {valid, owner}.
  - Beats return in issue order, one per cycle, with no gaps within a burst.
- enb is held high whenever BURST is active or the read pipeline is non-empty. The BRAM pipeline returns garbage if enb drops mid-flight, so this is mandatory.
- Read-after-write: a read issued in the cycle after a write to the same address returns the new data. There is no forwarding; the BRAM write commits at the edge.
- Write beats produce no rvalid.
- Deasserting req_i mid-burst has no effect; the burst runs to completion.
- Read pipeline drain overlaps the IDLE bubble and the next grant. rvalid for the previous owner may coincide with gnt of the new owner.
- busy_o = (state==BURST) | any pipeline valid.
- Reset mid-burst: the next cycle is IDLE, the pipeline is flushed, no rvalid is emitted for in-flight reads, and web/enb are 0.
- Address range is not checked; BRAM depth is software's responsibility.

Decomposition:
- Package bram_rf_pkg:
  - ADDR_W, DATA_W, LEN_W, RD_LAT constants.
  - state enum typedef {IDLE, BURST}.
  - WE_FULL = 4'b1111.
  - typedef rd_tag_t {logic valid; logic [$clog2(N_REQ)-1:0] owner;}.
- One sub-module: rr_arbiter (N_REQ) — combinational round-robin pick from req vector and rr_ptr, returning a one-hot grant and an index.

Test Plan:
- Read burst, req0, addr=1, len=3, BRAM preloaded (BRAM[1..4] = 15, 20, 42, 65) → gnt_o[0] at t+1..t+4, then rvalid_o[0] at t+3..t+6 with rdata 15, 20, 42, 65; enb high t+1..t+6.
- Write burst, req1, addr=33, len=1, wdata 1111 then 2222 → web=4'b1111 at t+1, t+2. A following req1 read of 33..34 returns 1111, 2222 with no rvalid during the writes.
- req0..req3 all asserted, len=0, rr_ptr=0 → grants in order 0, 1, 2, 3 with one IDLE bubble between each. Re-asserting all four again yields order 0, 1, 2, 3; no requester is starved.
- Wrap: req2 read, addr=8190, len=3 → addrb sequence 8190, 8191, 0, 1.
- RST asserted at the 2nd beat of a len=7 read → next cycle: state IDLE, gnt_o=0, enb=0, and no rvalid_o over the following 3 cycles.
- Back-to-back: req0 read len=0 followed immediately by req1 write → the req0 rvalid and the req1 gnt/web overlap in the same cycle, and the data is correct.
